// File: rtl/rts_bist_ctrl_mc.sv
// Multi-chain RTS BIST session controller: init, load/capture rounds, unload, on-chip signature compare.
// Optional macro RTS_CYCLE_CNT_EN enables the saturating tick_cnt session-cycle counter.
module rts_bist_ctrl_mc #(
   parameter int NUM_CHAINS = 2,
   parameter int CNT_W      = 8,
   parameter int RND_W      = 16,
   parameter int MISR_W     = 24,
   parameter int SISA_W     = 16
) (
   input  logic                         clk,
   input  logic                         masterRst,
   input  logic                         start,
   input  logic [CNT_W-1:0]             shift_len,
   input  logic [RND_W-1:0]             num_rounds,
   input  logic [NUM_CHAINS-1:0]        chain_mask,
   input  logic [MISR_W-1:0]            misr_sig,
   input  logic [NUM_CHAINS*SISA_W-1:0] sisa_sig,
   input  logic [MISR_W-1:0]            golden_misr,
   input  logic [NUM_CHAINS*SISA_W-1:0] golden_sisa,
   output logic                         NbarT,
   output logic                         internalRst,
   output logic                         PRPG_En,
   output logic                         MISR_En,
   output logic [NUM_CHAINS-1:0]        SRSG_En,
   output logic [NUM_CHAINS-1:0]        SISA_En,
   output logic                         busy,
   output logic                         done,
   output logic                         pass,
   output logic                         fail_misr,
   output logic [NUM_CHAINS-1:0]        fail_sisa,
   output logic [RND_W-1:0]             round_cnt,
   output logic [31:0]                  tick_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_INIT, ST_LOAD, ST_CAPTURE, ST_UNLOAD, ST_COMPARE, ST_DONE
   } state_t;

   state_t                r_state;
   logic [CNT_W-1:0]      r_shift_len;
   logic [CNT_W-1:0]      r_shift_cnt;
   logic [RND_W-1:0]      r_num_rounds;
   logic [NUM_CHAINS-1:0] r_mask;
   logic [NUM_CHAINS-1:0] w_sisa_neq;
   logic                  w_start_ok;

   generate
      for (genvar gi = 0; gi < NUM_CHAINS; gi++) begin : g_sisa_cmp
         assign w_sisa_neq[gi] = sisa_sig[gi*SISA_W +: SISA_W] != golden_sisa[gi*SISA_W +: SISA_W];
      end
   endgenerate

   assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE);

   // Outputs are assigned for the state being entered, so they line up with r_state.
   always_ff @(posedge clk) begin
      if (masterRst) begin
         r_state      <= ST_IDLE;
         r_shift_len  <= '0;
         r_shift_cnt  <= '0;
         r_num_rounds <= '0;
         r_mask       <= '0;
         NbarT        <= 1'b0;
         internalRst  <= 1'b1;
         PRPG_En      <= 1'b0;
         MISR_En      <= 1'b0;
         SRSG_En      <= '0;
         SISA_En      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
         fail_misr    <= 1'b0;
         fail_sisa    <= '0;
         round_cnt    <= '0;
      end else begin
         NbarT       <= 1'b0;
         internalRst <= 1'b0;
         PRPG_En     <= 1'b0;
         MISR_En     <= 1'b0;
         SRSG_En     <= '0;
         SISA_En     <= '0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_shift_len  <= (shift_len == '0) ? CNT_W'(1) : shift_len;
                  r_num_rounds <= (num_rounds == '0) ? RND_W'(1) : num_rounds;
                  r_mask       <= (chain_mask == '0) ? '1 : chain_mask;
                  fail_misr    <= 1'b0;
                  fail_sisa    <= '0;
                  pass         <= 1'b0;
                  done         <= 1'b0;
                  busy         <= 1'b1;
                  internalRst  <= 1'b1;
                  round_cnt    <= RND_W'(1);
                  r_state      <= ST_INIT;
               end
            end
            ST_INIT: begin
               r_shift_cnt <= r_shift_len - CNT_W'(1);
               NbarT       <= 1'b1;
               SRSG_En     <= r_mask;
               SISA_En     <= r_mask;
               r_state     <= ST_LOAD;
            end
            ST_LOAD: begin
               if (r_shift_cnt == '0) begin
                  PRPG_En <= 1'b1;
                  MISR_En <= 1'b1;
                  r_state <= ST_CAPTURE;
               end else begin
                  r_shift_cnt <= r_shift_cnt - CNT_W'(1);
                  NbarT       <= 1'b1;
                  SRSG_En     <= r_mask;
                  SISA_En     <= r_mask;
               end
            end
            ST_CAPTURE: begin
               r_shift_cnt <= r_shift_len - CNT_W'(1);
               NbarT       <= 1'b1;
               SRSG_En     <= r_mask;
               SISA_En     <= r_mask;
               if (round_cnt < r_num_rounds) begin
                  round_cnt <= round_cnt + RND_W'(1);
                  r_state   <= ST_LOAD;
               end else begin
                  r_state   <= ST_UNLOAD;
               end
            end
            ST_UNLOAD: begin
               if (r_shift_cnt == '0) begin
                  r_state <= ST_COMPARE;
               end else begin
                  r_shift_cnt <= r_shift_cnt - CNT_W'(1);
                  NbarT       <= 1'b1;
                  SRSG_En     <= r_mask;
                  SISA_En     <= r_mask;
               end
            end
            ST_COMPARE: begin
               fail_misr <= misr_sig != golden_misr;
               fail_sisa <= r_mask & w_sisa_neq;
               pass      <= (misr_sig == golden_misr) && ((r_mask & w_sisa_neq) == '0);
               done      <= 1'b1;
               busy      <= 1'b0;
               r_state   <= ST_DONE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef RTS_CYCLE_CNT_EN
   logic [31:0] r_tick;
   // Incremented on each edge leaving INIT..COMPARE, so DONE shows the session length.
   always_ff @(posedge clk) begin
      if (masterRst || w_start_ok) begin
         r_tick <= '0;
      end else if (r_state != ST_IDLE && r_state != ST_DONE && r_tick != 32'hFFFF_FFFF) begin
         r_tick <= r_tick + 32'd1;
      end
   end
   assign tick_cnt = r_tick;
`else
   assign tick_cnt = 32'd0;
`endif

endmodule
